// File: rtl/id_ex_stage_pkg.sv
// ID/EX shared types and constants.
// Used by the decoder, the ID/EX stage and the ALU.
package id_ex_stage_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int ALU_OP_W = 4;
  localparam int IMM_W = 16;
  localparam int CNT_W = 16;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_LUI  = 4'd11
  } alu_op_e;

  typedef struct packed {
    logic                reg_write;
    logic                mem_read;
    logic                mem_write;
    logic                alu_src;
    logic [ALU_OP_W-1:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Load-use hazard detect for the ID/EX stage.
// Pure combinational; stalls ID behind a load.
module load_use_detect
  import id_ex_stage_pkg::*;
(
  input  logic       id_valid_i,
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  logic       ex_valid_i,
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_dest_i,
  output logic       stall_o
);

  logic dest_hit;

  // Stall when a live load in EX feeds a source in ID
  always_comb begin
    dest_hit = (ex_dest_i == id_rs_i)
             | (ex_dest_i == id_rt_i);
    stall_o  = id_valid_i
             & ex_valid_i
             & ex_mem_read_i
             & (ex_dest_i != REG_ZERO)
             & dest_hit;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with WB bypass,
// load-use bubble insertion and bubble counter.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DW = 32,
  // debug preload of the bubble counter
  parameter logic [CNT_W-1:0] BUBBLE_CNT_INIT = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                id_valid_i,
  input  logic [4:0]          id_rs_i,
  input  logic [4:0]          id_rt_i,
  input  logic [4:0]          id_rd_i,
  input  logic [IMM_W-1:0]    id_imm_i,
  input  logic                id_reg_write_i,
  input  logic                id_mem_read_i,
  input  logic                id_mem_write_i,
  input  logic                id_alu_src_i,
  input  logic                id_reg_dst_i,
  input  logic [ALU_OP_W-1:0] id_alu_op_i,
  input  logic [DW-1:0]       rf_data1_i,
  input  logic [DW-1:0]       rf_data2_i,
  input  logic                wb_reg_write_i,
  input  logic [4:0]          wb_write_reg_i,
  input  logic [DW-1:0]       wb_write_data_i,
  input  logic                flush_i,
  output logic                stall_o,
  output logic                ex_valid_o,
  output logic [DW-1:0]       ex_a_o,
  output logic [DW-1:0]       ex_b_o,
  output logic [DW-1:0]       ex_imm_o,
  output logic [4:0]          ex_rs_o,
  output logic [4:0]          ex_rt_o,
  output logic [4:0]          ex_dest_o,
  output logic                ex_reg_write_o,
  output logic                ex_mem_read_o,
  output logic                ex_mem_write_o,
  output logic                ex_alu_src_o,
  output logic [ALU_OP_W-1:0] ex_alu_op_o,
  output logic [CNT_W-1:0]    bubble_cnt_o
);

  logic          stall;
  logic          bubble;
  logic          wb_live;
  ctrl_t         id_ctrl;
  ctrl_t         ex_ctrl_q;
  logic          ex_valid_q;
  logic [DW-1:0] a_byp;
  logic [DW-1:0] b_byp;
  logic [DW-1:0] imm_ext;
  logic [4:0]    dest_sel;
  logic [DW-1:0] ex_a_q;
  logic [DW-1:0] ex_b_q;
  logic [DW-1:0] ex_imm_q;
  logic [4:0]    ex_rs_q;
  logic [4:0]    ex_rt_q;
  logic [4:0]    ex_dest_q;
  logic [CNT_W-1:0] cnt_q;

  load_use_detect u_lud (
    .id_valid_i    (id_valid_i),
    .id_rs_i       (id_rs_i),
    .id_rt_i       (id_rt_i),
    .ex_valid_i    (ex_valid_q),
    .ex_mem_read_i (ex_ctrl_q.mem_read),
    .ex_dest_i     (ex_dest_q),
    .stall_o       (stall)
  );

  // Control bundle; an invalid ID slot carries no side effects
  always_comb begin
    id_ctrl = CTRL_NOP;
    if (id_valid_i) begin
      id_ctrl.reg_write = id_reg_write_i;
      id_ctrl.mem_read  = id_mem_read_i;
      id_ctrl.mem_write = id_mem_write_i;
      id_ctrl.alu_src   = id_alu_src_i;
      id_ctrl.alu_op    = id_alu_op_i;
    end
  end

  // Same-cycle WB bypass, immediate extend, dest select
  always_comb begin
    wb_live  = wb_reg_write_i
             & (wb_write_reg_i != REG_ZERO);
    a_byp    = rf_data1_i;
    b_byp    = rf_data2_i;
    if (wb_live && wb_write_reg_i == id_rs_i)
      a_byp = wb_write_data_i;
    if (wb_live && wb_write_reg_i == id_rt_i)
      b_byp = wb_write_data_i;
    imm_ext  = {{(DW-IMM_W){id_imm_i[IMM_W-1]}},
                id_imm_i};
    dest_sel = id_reg_dst_i ? id_rd_i : id_rt_i;
    bubble   = flush_i | stall;
  end

  // Pipeline register; flush and stall both inject a bubble
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid_q <= 1'b0;
      ex_ctrl_q  <= CTRL_NOP;
      ex_a_q     <= '0;
      ex_b_q     <= '0;
      ex_imm_q   <= '0;
      ex_rs_q    <= '0;
      ex_rt_q    <= '0;
      ex_dest_q  <= '0;
    end else if (bubble) begin
      ex_valid_q <= 1'b0;
      ex_ctrl_q  <= CTRL_NOP;
      ex_a_q     <= '0;
      ex_b_q     <= '0;
      ex_imm_q   <= '0;
      ex_rs_q    <= '0;
      ex_rt_q    <= '0;
      ex_dest_q  <= '0;
    end else begin
      ex_valid_q <= id_valid_i;
      ex_ctrl_q  <= id_ctrl;
      ex_a_q     <= a_byp;
      ex_b_q     <= b_byp;
      ex_imm_q   <= imm_ext;
      ex_rs_q    <= id_rs_i;
      ex_rt_q    <= id_rt_i;
      ex_dest_q  <= dest_sel;
    end
  end

  // Saturating count of load-use bubbles not masked by flush
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      cnt_q <= BUBBLE_CNT_INIT;
    else if (stall && !flush_i && cnt_q != '1)
      cnt_q <= cnt_q + 1'b1;
  end

  assign stall_o        = stall;
  assign ex_valid_o     = ex_valid_q;
  assign ex_a_o         = ex_a_q;
  assign ex_b_o         = ex_b_q;
  assign ex_imm_o       = ex_imm_q;
  assign ex_rs_o        = ex_rs_q;
  assign ex_rt_o        = ex_rt_q;
  assign ex_dest_o      = ex_dest_q;
  assign ex_reg_write_o = ex_ctrl_q.reg_write;
  assign ex_mem_read_o  = ex_ctrl_q.mem_read;
  assign ex_mem_write_o = ex_ctrl_q.mem_write;
  assign ex_alu_src_o   = ex_ctrl_q.alu_src;
  assign ex_alu_op_o    = ex_ctrl_q.alu_op;
  assign bubble_cnt_o   = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed cases plus
// random traffic against a behavioural model.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [15:0] id_imm;
  logic        id_rw, id_mr, id_mw, id_as, id_rdst;
  logic [3:0]  id_op;
  logic [31:0] d1, d2;
  logic        wb_we;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        flush;

  logic        stall_o, ex_valid;
  logic [31:0] ex_a, ex_b, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_dest;
  logic        ex_rw, ex_mr, ex_mw, ex_as;
  logic [3:0]  ex_op;
  logic [15:0] cnt;

  logic        s_stall, s_valid;
  logic [31:0] s_a, s_b, s_imm;
  logic [4:0]  s_rs, s_rt, s_dest;
  logic        s_rw, s_mr, s_mw, s_as;
  logic [3:0]  s_op;
  logic [15:0] s_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  bit          m_valid;
  logic [31:0] m_a, m_b, m_imm;
  logic [4:0]  m_rs, m_rt, m_dest;
  bit          m_rw, m_mr, m_mw, m_as;
  logic [3:0]  m_op;
  int          m_cnt;
  int          m_cnt2;

  localparam int SAT_INIT = 32'hFFF0;

  always #5 clk = ~clk;

  id_ex_stage #(.DW(32)) dut (
    .clk(clk), .reset(reset),
    .id_valid_i(id_valid),
    .id_rs_i(id_rs), .id_rt_i(id_rt),
    .id_rd_i(id_rd), .id_imm_i(id_imm),
    .id_reg_write_i(id_rw),
    .id_mem_read_i(id_mr),
    .id_mem_write_i(id_mw),
    .id_alu_src_i(id_as),
    .id_reg_dst_i(id_rdst),
    .id_alu_op_i(id_op),
    .rf_data1_i(d1), .rf_data2_i(d2),
    .wb_reg_write_i(wb_we),
    .wb_write_reg_i(wb_reg),
    .wb_write_data_i(wb_data),
    .flush_i(flush), .stall_o(stall_o),
    .ex_valid_o(ex_valid),
    .ex_a_o(ex_a), .ex_b_o(ex_b),
    .ex_imm_o(ex_imm),
    .ex_rs_o(ex_rs), .ex_rt_o(ex_rt),
    .ex_dest_o(ex_dest),
    .ex_reg_write_o(ex_rw),
    .ex_mem_read_o(ex_mr),
    .ex_mem_write_o(ex_mw),
    .ex_alu_src_o(ex_as),
    .ex_alu_op_o(ex_op),
    .bubble_cnt_o(cnt)
  );

  id_ex_stage #(
    .DW(32),
    .BUBBLE_CNT_INIT(16'hFFF0)
  ) dut_sat (
    .clk(clk), .reset(reset),
    .id_valid_i(id_valid),
    .id_rs_i(id_rs), .id_rt_i(id_rt),
    .id_rd_i(id_rd), .id_imm_i(id_imm),
    .id_reg_write_i(id_rw),
    .id_mem_read_i(id_mr),
    .id_mem_write_i(id_mw),
    .id_alu_src_i(id_as),
    .id_reg_dst_i(id_rdst),
    .id_alu_op_i(id_op),
    .rf_data1_i(d1), .rf_data2_i(d2),
    .wb_reg_write_i(wb_we),
    .wb_write_reg_i(wb_reg),
    .wb_write_data_i(wb_data),
    .flush_i(flush), .stall_o(s_stall),
    .ex_valid_o(s_valid),
    .ex_a_o(s_a), .ex_b_o(s_b),
    .ex_imm_o(s_imm),
    .ex_rs_o(s_rs), .ex_rt_o(s_rt),
    .ex_dest_o(s_dest),
    .ex_reg_write_o(s_rw),
    .ex_mem_read_o(s_mr),
    .ex_mem_write_o(s_mw),
    .ex_alu_src_o(s_as),
    .ex_alu_op_o(s_op),
    .bubble_cnt_o(s_cnt)
  );

  task automatic check(string tag,
                       logic [31:0] got,
                       logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h",
               tag, got, exp);
    end
  endtask

  function automatic bit m_stall();
    bit hit;
    hit = (m_dest == id_rs) || (m_dest == id_rt);
    return id_valid && m_valid && m_mr &&
           m_dest != 0 && hit;
  endfunction

  task automatic m_clear();
    m_valid = 0; m_a = 0; m_b = 0; m_imm = 0;
    m_rs = 0; m_rt = 0; m_dest = 0;
    m_rw = 0; m_mr = 0; m_mw = 0; m_as = 0;
    m_op = 0;
  endtask

  task automatic m_step();
    bit st;
    st = m_stall();
    if (st && !flush) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt2 < 65535) m_cnt2++;
    end
    if (flush || st) begin
      m_clear();
    end else begin
      m_valid = id_valid;
      m_a = d1;
      m_b = d2;
      if (wb_we && wb_reg != 0) begin
        if (wb_reg == id_rs) m_a = wb_data;
        if (wb_reg == id_rt) m_b = wb_data;
      end
      m_imm  = 32'(signed'(id_imm));
      m_rs   = id_rs;
      m_rt   = id_rt;
      m_dest = id_rdst ? id_rd : id_rt;
      m_rw   = id_valid && id_rw;
      m_mr   = id_valid && id_mr;
      m_mw   = id_valid && id_mw;
      m_as   = id_valid && id_as;
      m_op   = id_valid ? id_op : 4'd0;
    end
  endtask

  task automatic cmp_all();
    check("valid", ex_valid, m_valid);
    check("a", ex_a, m_a);
    check("b", ex_b, m_b);
    check("imm", ex_imm, m_imm);
    check("rs", ex_rs, m_rs);
    check("rt", ex_rt, m_rt);
    check("dest", ex_dest, m_dest);
    check("ctrl",
          {ex_rw, ex_mr, ex_mw, ex_as, ex_op},
          {m_rw, m_mr, m_mw, m_as, m_op});
    check("cnt", cnt, m_cnt);
    check("sat_cnt", s_cnt, m_cnt2);
  endtask

  task automatic idle();
    id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0;
    id_imm = 0; id_rw = 0; id_mr = 0; id_mw = 0;
    id_as = 0; id_rdst = 0; id_op = 0;
    d1 = 0; d2 = 0;
    wb_we = 0; wb_reg = 0; wb_data = 0;
    flush = 0;
  endtask

  task automatic cycle();
    #1;
    check("stall", stall_o, m_stall());
    @(posedge clk);
    m_step();
    #1;
    cmp_all();
    @(negedge clk);
  endtask

  task automatic ld8();
    idle();
    id_valid = 1; id_mr = 1; id_rw = 1;
    id_rt = 8; id_rs = 2; id_rdst = 0;
    cycle();
  endtask

  task automatic rnd_inputs();
    id_valid = ($urandom_range(0, 9) < 8);
    id_rs   = 5'($urandom_range(0, 7));
    id_rt   = 5'($urandom_range(0, 7));
    id_rd   = 5'($urandom_range(0, 7));
    id_imm  = 16'($urandom);
    id_rw   = 1'($urandom);
    id_mr   = 1'($urandom);
    id_mw   = 1'($urandom);
    id_as   = 1'($urandom);
    id_rdst = 1'($urandom);
    id_op   = 4'($urandom);
    d1      = $urandom;
    d2      = $urandom;
    wb_we   = 1'($urandom);
    wb_reg  = 5'($urandom_range(0, 7));
    wb_data = $urandom;
    flush   = ($urandom_range(0, 9) == 0);
  endtask

  initial begin
    idle();
    m_clear();
    m_cnt = 0;
    m_cnt2 = SAT_INIT;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_stall", stall_o, 0);
    check("rst_valid", ex_valid, 0);
    check("rst_cnt", cnt, 0);
    cmp_all();
    reset = 1;
    @(negedge clk);

    // plain capture
    idle();
    id_valid = 1; id_rs = 5; id_rt = 6;
    d1 = 32'h11; d2 = 32'h22; id_imm = 16'hFFFE;
    cycle();
    check("cap_a", ex_a, 32'h11);
    check("cap_b", ex_b, 32'h22);
    check("cap_imm", ex_imm, 32'hFFFF_FFFE);
    check("cap_valid", ex_valid, 1);

    // bypass
    idle();
    id_valid = 1; id_rs = 5; id_rt = 6;
    d1 = 32'h55; d2 = 32'h66;
    wb_we = 1; wb_reg = 5; wb_data = 32'hDEAD_BEEF;
    cycle();
    check("byp_a", ex_a, 32'hDEAD_BEEF);
    check("byp_b", ex_b, 32'h66);
    idle();
    id_valid = 1; id_rs = 0; d1 = 32'h1234;
    wb_we = 1; wb_reg = 0; wb_data = 32'hCAFE_F00D;
    cycle();
    check("byp_r0", ex_a, 32'h1234);

    // load-use
    ld8();
    idle();
    id_valid = 1; id_rs = 8; id_rt = 1;
    id_rw = 1; id_rdst = 1; id_rd = 9;
    #1 check("lu_stall", stall_o, 1);
    cycle();
    check("lu_valid", ex_valid, 0);
    check("lu_ctrl", {ex_rw, ex_mr, ex_mw}, 0);
    check("lu_cnt", cnt, 1);
    #1 check("lu_stall_drop", stall_o, 0);
    cycle();
    check("lu_cap_valid", ex_valid, 1);
    check("lu_cap_dest", ex_dest, 9);

    // flush while stalled
    ld8();
    idle();
    id_valid = 1; id_rs = 8; flush = 1;
    #1 check("fs_stall", stall_o, 1);
    cycle();
    check("fs_valid", ex_valid, 0);
    check("fs_cnt", cnt, 1);

    // dest select
    idle();
    id_valid = 1; id_rdst = 1; id_rd = 3; id_rt = 9;
    cycle();
    check("dst_rd", ex_dest, 3);
    id_rdst = 0;
    cycle();
    check("dst_rt", ex_dest, 9);

    // load to r0 never stalls
    idle();
    id_valid = 1; id_mr = 1; id_rdst = 1; id_rd = 0;
    cycle();
    idle();
    id_valid = 1; id_rs = 0; id_rt = 0;
    #1 check("r0_nostall", stall_o, 0);
    cycle();

    // async reset between edges
    idle();
    id_valid = 1; id_rs = 4; id_rw = 1;
    d1 = 32'h77; id_imm = 16'h0042;
    cycle();
    #2 reset = 0;
    #1;
    m_clear();
    m_cnt = 0;
    m_cnt2 = SAT_INIT;
    check("ar_valid", ex_valid, 0);
    check("ar_a", ex_a, 0);
    check("ar_rw", ex_rw, 0);
    check("ar_stall", stall_o, 0);
    cmp_all();
    @(negedge clk);
    reset = 1;
    @(negedge clk);

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      rnd_inputs();
      cycle();
    end

    // drive the preloaded counter into saturation
    for (int i = 0; i < 20; i++) begin
      ld8();
      idle();
      id_valid = 1; id_rs = 8;
      cycle();
    end
    check("sat_final", s_cnt, 16'hFFFF);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
